// File: rtl/branch_pc_unit_if.sv
// Decoder/ALU-to-branch-unit bundle: strobes, flags and operands in, fetch PC and status out.
// No internal latency; the master drives inputs, the slave (branch_pc_unit) drives outputs.
// Backpressure is the stall input, which freezes all branch-unit state.
interface branch_pc_unit_if #(
    parameter int ADDR_W = 32
);
    logic              instr_valid;
    logic              stall;
    logic [31:0]       instruction;
    logic [ADDR_W-1:0] rs_data;
    logic b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret;
    logic zero, carry, sign, overflow;
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic              flush;
    logic              ras_empty;
    logic              ras_err;

    modport master (
        output instr_valid, stall, instruction, rs_data,
        output b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret,
        output zero, carry, sign, overflow,
        input  pc, taken, flush, ras_empty, ras_err
    );

    modport slave (
        input  instr_valid, stall, instruction, rs_data,
        input  b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret,
        input  zero, carry, sign, overflow,
        output pc, taken, flush, ras_empty, ras_err
    );
endinterface

// File: rtl/branch_pc_unit.sv
// Branch resolution and PC owner with a circular return-address stack for Call/Ret.
// One-edge latency: pc/taken/flush/RAS state update on the edge after a valid, unstalled cycle.
// stall=1 or instr_valid=0 holds pc, RAS and ras_err; taken/flush drop to 0.
module branch_pc_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    branch_pc_unit_if.slave bus
);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic              r_taken;
    logic              r_ras_err;
    logic              r_ras_empty;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_top;
    logic [ADDR_W-1:0] r_stack [RAS_DEPTH];

    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_tgt;
    logic              w_upd;
    logic              w_cond;
    logic              w_push;
    logic              w_pop;
    logic              w_err_set;
    logic              w_taken_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [CW-1:0]     w_count_nxt;
    logic [PW-1:0]     w_top_nxt;
    logic [PW-1:0]     w_top_inc;
    logic              w_unused;

    assign w_unused  = ^bus.instruction[31:26];
    assign w_seq     = r_pc + 1'b1;
    assign w_off     = {{(ADDR_W-26){bus.instruction[25]}}, bus.instruction[25:0]};
    assign w_tgt     = w_seq + w_off;
    assign w_upd     = bus.instr_valid & ~bus.stall;
    assign w_top_inc = r_top + 1'b1;

    assign w_cond = (bus.bz   &  bus.zero)     | (bus.bnz  & ~bus.zero)  |
                    (bus.bcy  &  bus.carry)    | (bus.bncy & ~bus.carry) |
                    (bus.bs   &  bus.sign)     | (bus.bns  & ~bus.sign)  |
                    (bus.bv   &  bus.overflow) | (bus.bnv  & ~bus.overflow);

    always_comb begin
        w_pc_nxt    = r_pc;
        w_taken_nxt = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_err_set   = 1'b0;
        if (w_upd) begin
            if (bus.Ret) begin
                if (r_count != '0) begin
                    w_pc_nxt    = r_stack[r_top];
                    w_pop       = 1'b1;
                    w_taken_nxt = 1'b1;
                end else begin
                    w_pc_nxt  = w_seq;
                    w_err_set = 1'b1;
                end
            end else if (bus.Call) begin
                w_pc_nxt    = w_tgt;
                w_push      = 1'b1;
                w_taken_nxt = 1'b1;
            end else if (bus.br) begin
                w_pc_nxt    = bus.rs_data;
                w_taken_nxt = 1'b1;
            end else if (bus.b || w_cond) begin
                w_pc_nxt    = w_tgt;
                w_taken_nxt = 1'b1;
            end else begin
                w_pc_nxt = w_seq;
            end
        end
    end

    // A full stack keeps pushing over its oldest entry; count just saturates.
    always_comb begin
        w_count_nxt = r_count;
        w_top_nxt   = r_top;
        if (w_push) begin
            w_top_nxt   = w_top_inc;
            w_count_nxt = (r_count == FULL) ? FULL : r_count + 1'b1;
        end else if (w_pop) begin
            w_top_nxt   = r_top - 1'b1;
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_taken     <= 1'b0;
            r_ras_err   <= 1'b0;
            r_ras_empty <= 1'b1;
            r_count     <= '0;
            r_top       <= '1;
        end else begin
            r_pc        <= w_pc_nxt;
            r_taken     <= w_taken_nxt;
            r_ras_err   <= r_ras_err | w_err_set;
            r_ras_empty <= (w_count_nxt == '0);
            r_count     <= w_count_nxt;
            r_top       <= w_top_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_top_inc] <= w_seq;
        end
    end

    assign bus.pc        = r_pc;
    assign bus.taken     = r_taken;
    assign bus.flush     = r_taken;
    assign bus.ras_empty = r_ras_empty;
    assign bus.ras_err   = r_ras_err;
endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed table-driven bench for branch_pc_unit plus stall and async-reset sequences.
module tb_branch_pc_unit;
    localparam logic [11:0] S_NONE = 12'h000, S_RET = 12'h800, S_CALL = 12'h400,
                            S_BR = 12'h200, S_B = 12'h100, S_BZ = 12'h080, S_BNZ = 12'h040,
                            S_BCY = 12'h020, S_BNCY = 12'h010, S_BS = 12'h008,
                            S_BNV = 12'h001;
    // flags packed as {zero, carry, sign, overflow}
    localparam logic [3:0] F_Z = 4'b1000, F_C = 4'b0100, F_S = 4'b0010, F_V = 4'b0001;

    typedef struct {
        logic [11:0] stb;
        logic [3:0]  flg;
        logic [25:0] off;
        logic [31:0] rs;
        logic        vld;
        logic [31:0] e_pc;
        logic        e_tk;
        logic        e_empty;
        logic        e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vt[$];

    branch_pc_unit_if #(.ADDR_W(32)) bus ();

    branch_pc_unit #(.ADDR_W(32), .RESET_PC(32'd0), .RAS_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [11:0] stb, input logic [3:0] flg, input logic [25:0] off,
                         input logic [31:0] rs, input logic vld, input logic stl);
        {bus.Ret, bus.Call, bus.br, bus.b, bus.bz, bus.bnz, bus.bcy, bus.bncy,
         bus.bs, bus.bns, bus.bv, bus.bnv} = stb;
        {bus.zero, bus.carry, bus.sign, bus.overflow} = flg;
        bus.instruction = {6'd0, off};
        bus.rs_data     = rs;
        bus.instr_valid = vld;
        bus.stall       = stl;
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic tk,
                             input logic emp, input logic err);
        check({tag, ".pc"}, bus.pc, pc);
        check({tag, ".taken"}, {31'd0, bus.taken}, {31'd0, tk});
        check({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, tk});
        check({tag, ".ras_empty"}, {31'd0, bus.ras_empty}, {31'd0, emp});
        check({tag, ".ras_err"}, {31'd0, bus.ras_err}, {31'd0, err});
    endtask

    function automatic vec_t mk(input logic [11:0] stb, input logic [3:0] flg,
                                input logic [25:0] off, input logic [31:0] rs, input logic vld,
                                input logic [31:0] pc, input logic tk, input logic emp,
                                input logic err);
        vec_t v;
        v.stb = stb; v.flg = flg; v.off = off; v.rs = rs; v.vld = vld;
        v.e_pc = pc; v.e_tk = tk; v.e_empty = emp; v.e_err = err;
        return v;
    endfunction

    initial begin
        vt.push_back(mk(S_NONE, 4'b0, 26'd0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(S_NONE, 4'b0, 26'd0, 32'd0, 1'b1, 32'd2, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(S_NONE, 4'b0, 26'd0, 32'd0, 1'b1, 32'd3, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(S_BR,   4'b0, 26'd0, 32'd10, 1'b1, 32'd10, 1'b1, 1'b1, 1'b0));
        vt.push_back(mk(S_B,    4'b0, 26'h3FFFFFC, 32'd0, 1'b1, 32'd7, 1'b1, 1'b1, 1'b0));
        vt.push_back(mk(S_NONE, 4'b0, 26'd0, 32'd0, 1'b1, 32'd8, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(S_BR,   4'b0, 26'd0, 32'd20, 1'b1, 32'd20, 1'b1, 1'b1, 1'b0));
        vt.push_back(mk(S_BZ,   4'b0, 26'd5, 32'd0, 1'b1, 32'd21, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(S_BZ,   F_Z,  26'd5, 32'd0, 1'b1, 32'd27, 1'b1, 1'b1, 1'b0));
        vt.push_back(mk(S_BNV,  F_V,  26'd5, 32'd0, 1'b1, 32'd28, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(S_BR,   4'b0, 26'd0, 32'd5, 1'b1, 32'd5, 1'b1, 1'b1, 1'b0));
        vt.push_back(mk(S_CALL, 4'b0, 26'd10, 32'd0, 1'b1, 32'd16, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(S_RET,  4'b0, 26'd0, 32'd0, 1'b1, 32'd6, 1'b1, 1'b1, 1'b0));
        vt.push_back(mk(S_BR,   4'b0, 26'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0));
        // five nested calls overflow the 4-deep stack: return address 1 is lost
        vt.push_back(mk(S_CALL, 4'b0, 26'd99, 32'd0, 1'b1, 32'd100, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(S_CALL, 4'b0, 26'd99, 32'd0, 1'b1, 32'd200, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(S_CALL, 4'b0, 26'd99, 32'd0, 1'b1, 32'd300, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(S_CALL, 4'b0, 26'd99, 32'd0, 1'b1, 32'd400, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(S_CALL, 4'b0, 26'd99, 32'd0, 1'b1, 32'd500, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(S_RET,  4'b0, 26'd0, 32'd0, 1'b1, 32'd401, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(S_RET,  4'b0, 26'd0, 32'd0, 1'b1, 32'd301, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(S_RET,  4'b0, 26'd0, 32'd0, 1'b1, 32'd201, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(S_RET,  4'b0, 26'd0, 32'd0, 1'b1, 32'd101, 1'b1, 1'b1, 1'b0));
        vt.push_back(mk(S_RET,  4'b0, 26'd0, 32'd0, 1'b1, 32'd102, 1'b0, 1'b1, 1'b1));
        vt.push_back(mk(S_NONE, 4'b0, 26'd0, 32'd0, 1'b1, 32'd103, 1'b0, 1'b1, 1'b1));
        vt.push_back(mk(S_B,    4'b0, 26'd9, 32'd0, 1'b0, 32'd103, 1'b0, 1'b1, 1'b1));
        vt.push_back(mk(S_BR | S_B, 4'b0, 26'd0, 32'd50, 1'b1, 32'd50, 1'b1, 1'b1, 1'b1));
        vt.push_back(mk(S_BNZ,  4'b0, 26'd2, 32'd0, 1'b1, 32'd53, 1'b1, 1'b1, 1'b1));
        vt.push_back(mk(S_BCY,  F_C,  26'h3FFFFFF, 32'd0, 1'b1, 32'd53, 1'b1, 1'b1, 1'b1));
        vt.push_back(mk(S_BNCY, F_C,  26'd7, 32'd0, 1'b1, 32'd54, 1'b0, 1'b1, 1'b1));
        vt.push_back(mk(S_RET | S_CALL, 4'b0, 26'd7, 32'd0, 1'b1, 32'd55, 1'b0, 1'b1, 1'b1));
        vt.push_back(mk(S_BS,   F_S,  26'd0, 32'd0, 1'b1, 32'd56, 1'b1, 1'b1, 1'b1));
        vt.push_back(mk(S_BR,   4'b0, 26'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1));
        vt.push_back(mk(S_NONE, 4'b0, 26'd0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1));

        drive(S_NONE, 4'b0, 26'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 32'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check_all("post_reset", 32'd0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].stb, vt[i].flg, vt[i].off, vt[i].rs, vt[i].vld, 1'b0);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_tk, vt[i].e_empty,
                      vt[i].e_err);
            @(negedge clk);
        end

        // stall freezes pc despite a b strobe; releasing it lets the branch through
        for (int i = 0; i < 3; i++) begin
            drive(S_B, 4'b0, 26'd10, 32'd0, 1'b1, 1'b1);
            @(posedge clk);
            #1;
            check_all($sformatf("stall%0d", i), 32'd0, 1'b0, 1'b1, 1'b1);
            @(negedge clk);
        end
        drive(S_B, 4'b0, 26'd10, 32'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_all("unstall", 32'd11, 1'b1, 1'b1, 1'b1);

        // async reset between edges takes effect without a clock edge
        @(negedge clk);
        drive(S_NONE, 4'b0, 26'd0, 32'd0, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1;
        check_all("async_rst", 32'd0, 1'b0, 1'b1, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("after_rst", 32'd1, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
